// File: rtl/gate_truth_table_checker.sv
// Self-test sequencer for the 2-input logic-gate block: walks a/b through all
// four combinations, waits SETTLE cycles per vector, compares the 7-bit gate
// result against the truth table and reports pass / error mask / error count.
module gate_truth_table_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [6:0] y,
  output logic       a,
  output logic       b,
  output logic [1:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] err_mask,
  output logic [2:0] err_count
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CHECK,
    FINISH
  } state_e;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  // Gate result bit order: [0] AND, [1] OR, [2] NOT a, [3] NAND, [4] NOR,
  // [5] XOR, [6] XNOR; vector index is {a, b}.
  function automatic logic [6:0] expected_y(input logic [1:0] v);
    logic [6:0] e;
    case (v)
      2'd0:    e = 7'h5C;
      2'd1:    e = 7'h2E;
      2'd2:    e = 7'h2A;
      default: e = 7'h43;
    endcase
    return e;
  endfunction

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] vec_q, vec_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [6:0] mask_q, mask_d;
  logic [2:0] count_q, count_d;
  logic [6:0] mism;

  // State and result registers; reset clears everything, including mid-pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end

  // Next-state logic; busy/done are computed from the next state so that the
  // registered outputs line up with the state they describe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    pass_d  = pass_q;
    mask_d  = mask_q;
    count_d = count_q;
    done_d  = 1'b0;
    mism    = y ^ expected_y(vec_q);

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = WAIT;
          vec_d   = '0;
          mask_d  = '0;
          count_d = '0;
          pass_d  = 1'b0;
          cnt_d   = SETTLE_LOAD;
        end
      end
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
          vec_d   = '0;
          pass_d  = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CHECK: begin
        if (abort) begin
          state_d = IDLE;
          vec_d   = '0;
          pass_d  = 1'b0;
        end else begin
          if (mism != '0) begin
            mask_d  = mask_q | mism;
            count_d = count_q + 3'd1;
          end
          if (vec_q == 2'd3) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT;
            vec_d   = vec_q + 2'd1;
            cnt_d   = SETTLE_LOAD;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        if (abort) begin
          vec_d  = '0;
          pass_d = 1'b0;
        end else begin
          pass_d = (count_q == '0);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign a         = vec_q[1];
  assign b         = vec_q[0];
  assign vec_idx   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_mask  = mask_q;
  assign err_count = count_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker: two instances (SETTLE=1 and SETTLE=4)
// driven by a behavioural gate block with injectable faults.
module tb_gate_truth_table_checker;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic [6:0] y1, y4;
  logic a1, b1, busy1, done1, pass1;
  logic a4, b4, busy4, done4, pass4;
  logic [1:0] vec1, vec4;
  logic [6:0] mask1, mask4;
  logic [2:0] cnt1, cnt4;

  logic [6:0] flip [4];
  logic [6:0] clr;
  logic       sel;

  logic       oa, ob, obusy, odone, opass;
  logic [1:0] ovec;
  logic [6:0] omask;
  logic [2:0] ocnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gate_truth_table_checker #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .y(y1),
    .a(a1), .b(b1), .vec_idx(vec1), .busy(busy1), .done(done1),
    .pass(pass1), .err_mask(mask1), .err_count(cnt1)
  );

  gate_truth_table_checker #(.SETTLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .y(y4),
    .a(a4), .b(b4), .vec_idx(vec4), .busy(busy4), .done(done4),
    .pass(pass4), .err_mask(mask4), .err_count(cnt4)
  );

  // Gate block behaviour from boolean definitions.
  function automatic logic [6:0] truth(input logic ia, input logic ib);
    return {~(ia ^ ib), ia ^ ib, ~(ia | ib), ~(ia & ib), ~ia, ia | ib, ia & ib};
  endfunction

  always_comb y1 = (truth(a1, b1) & ~clr) ^ flip[{a1, b1}];
  always_comb y4 = (truth(a4, b4) & ~clr) ^ flip[{a4, b4}];

  always_comb begin
    if (sel) begin
      oa = a4; ob = b4; ovec = vec4; obusy = busy4; odone = done4;
      opass = pass4; omask = mask4; ocnt = cnt4;
    end else begin
      oa = a1; ob = b1; ovec = vec1; obusy = busy1; odone = done1;
      opass = pass1; omask = mask1; ocnt = cnt1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_faults;
    for (int v = 0; v < 4; v++) flip[v] = '0;
    clr = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // One full pass on the selected instance, checked cycle by cycle against
  // the model's expected schedule and final result.
  task automatic run_pass(input string tag);
    logic [6:0] exp_mask;
    int         exp_cnt;
    int         len;
    logic [6:0] t, m;
    exp_mask = '0;
    exp_cnt  = 0;
    for (int v = 0; v < 4; v++) begin
      t = truth(v[1], v[0]);
      m = ((t & ~clr) ^ flip[v]) ^ t;
      if (m != '0) begin
        exp_mask = exp_mask | m;
        exp_cnt++;
      end
    end
    len = (sel ? 4 : 1) + 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (omask !== 7'h00 || ocnt !== 3'd0 || opass !== 1'b0) begin
      errors++;
      $display("FAIL %s_clear: mask=%h cnt=%0d pass=%b, want 00/0/0", tag, omask, ocnt, opass);
    end
    for (int k = 0; k < 4 * len; k++) begin
      checks++;
      if (obusy !== 1'b1 || odone !== 1'b0 || ovec !== 2'(k / len) || {oa, ob} !== 2'(k / len)) begin
        errors++;
        $display("FAIL %s_seq cyc%0d: busy=%b done=%b vec=%0d ab=%b%b, want 1/0/%0d", tag, k, obusy,
                 odone, ovec, oa, ob, k / len);
      end
      tick();
    end
    checks++;
    if (odone !== 1'b1 || obusy !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: done=%b busy=%b, want 1/1", tag, odone, obusy);
    end
    tick();
    checks++;
    if (odone !== 1'b0 || obusy !== 1'b0 || opass !== (exp_cnt == 0) ||
        omask !== exp_mask || ocnt !== 3'(exp_cnt)) begin
      errors++;
      $display("FAIL %s_result: done=%b busy=%b pass=%b mask=%h cnt=%0d, want 0/0/%b/%h/%0d", tag,
               odone, obusy, opass, omask, ocnt, exp_cnt == 0, exp_mask, exp_cnt);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    sel = 1'b0;
    clear_faults();
    tick();
    tick();
    checks++;
    if ({a1, b1, vec1, busy1, done1, pass1, mask1, cnt1} !== '0 ||
        {a4, b4, vec4, busy4, done4, pass4, mask4, cnt4} !== '0) begin
      errors++;
      $display("FAIL reset_values: dut1=%b%b %0d %b%b%b %h %0d", a1, b1, vec1, busy1, done1, pass1,
               mask1, cnt1);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_clean;
    do_reset();
    clear_faults();
    sel = 1'b0;
    run_pass("clean_s1");
  endtask

  task automatic test_xor_stuck;
    do_reset();
    clear_faults();
    clr = 7'b0100000;
    sel = 1'b0;
    run_pass("xor_low");
    checks++;
    if (mask1 !== 7'b0100000 || cnt1 !== 3'd2 || pass1 !== 1'b0) begin
      errors++;
      $display("FAIL xor_low_literal: mask=%h cnt=%0d pass=%b, want 20/2/0", mask1, cnt1, pass1);
    end
  endtask

  task automatic test_all_zero;
    do_reset();
    clear_faults();
    clr = 7'h7F;
    sel = 1'b1;
    run_pass("zero_s4");
    checks++;
    if (mask4 !== 7'h7F || cnt4 !== 3'd4 || pass4 !== 1'b0) begin
      errors++;
      $display("FAIL zero_s4_literal: mask=%h cnt=%0d pass=%b, want 7f/4/0", mask4, cnt4, pass4);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 12; it++) begin
      do_reset();
      sel = 1'($urandom_range(0, 1));
      for (int v = 0; v < 4; v++)
        flip[v] = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'h00;
      clr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00;
      run_pass("random");
    end
    clear_faults();
  endtask

  task automatic test_abort;
    logic [6:0] f0;
    do_reset();
    clear_faults();
    sel = 1'b0;
    f0 = 7'($urandom) | 7'h01;
    flip[0] = f0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (vec1 !== 2'd2) begin
      errors++;
      $display("FAIL abort_pre: vec=%0d, want 2", vec1);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || pass1 !== 1'b0 || {a1, b1} !== 2'b00 ||
        vec1 !== 2'd0 || mask1 !== f0 || cnt1 !== 3'd1) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b pass=%b ab=%b%b vec=%0d mask=%h cnt=%0d, want 0/0/0/00/0/%h/1",
               busy1, done1, pass1, a1, b1, vec1, mask1, cnt1, f0);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (done1 !== 1'b0 || busy1 !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet cyc%0d: done=%b busy=%b, want 0/0", k, done1, busy1);
      end
    end
    clear_faults();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || vec1 !== 2'd0 || mask1 !== 7'h00 || cnt1 !== 3'd0) begin
      errors++;
      $display("FAIL abort_restart: busy=%b vec=%0d mask=%h cnt=%0d, want 1/0/00/0", busy1, vec1,
               mask1, cnt1);
    end
  endtask

  task automatic test_abort_finish;
    do_reset();
    clear_faults();
    sel = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (done1 !== 1'b1) begin
      errors++;
      $display("FAIL abort_fin_done: done=%b, want 1", done1);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (pass1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0 || vec1 !== 2'd0 ||
        mask1 !== 7'h00 || cnt1 !== 3'd0) begin
      errors++;
      $display("FAIL abort_fin_state: pass=%b busy=%b done=%b vec=%0d mask=%h cnt=%0d, want 0/0/0/0/00/0",
               pass1, busy1, done1, vec1, mask1, cnt1);
    end
  endtask

  task automatic test_async_reset;
    logic [6:0] f0;
    do_reset();
    clear_faults();
    sel = 1'b0;
    f0 = 7'($urandom) | 7'h10;
    flip[0] = f0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (mask1 !== f0 || busy1 !== 1'b1 || vec1 !== 2'd1) begin
      errors++;
      $display("FAIL areset_pre: mask=%h busy=%b vec=%0d, want %h/1/1", mask1, busy1, vec1, f0);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({a1, b1, vec1, busy1, done1, pass1, mask1, cnt1} !== '0) begin
      errors++;
      $display("FAIL areset_now: ab=%b%b vec=%0d busy=%b done=%b pass=%b mask=%h cnt=%0d, want all 0",
               a1, b1, vec1, busy1, done1, pass1, mask1, cnt1);
    end
    #3;
    rst = 1'b0;
    clear_faults();
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (busy1 !== 1'b0 || vec1 !== 2'd0) begin
        errors++;
        $display("FAIL areset_idle cyc%0d: busy=%b vec=%0d, want 0/0", k, busy1, vec1);
      end
    end
  endtask

  task automatic test_start_held;
    do_reset();
    clear_faults();
    sel = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (done1 !== ((k == 8) || (k == 18)) || busy1 !== !((k == 9) || (k == 19))) begin
        errors++;
        $display("FAIL held_start edge%0d: done=%b busy=%b, want %b/%b", k, done1, busy1,
                 (k == 8) || (k == 18), !((k == 9) || (k == 19)));
      end
    end
    start = 1'b0;
    tick();
    checks++;
    if (busy1 !== 1'b0 || pass1 !== 1'b1) begin
      errors++;
      $display("FAIL held_end: busy=%b pass=%b, want 0/1", busy1, pass1);
    end
  endtask

  task automatic test_start_abort_idle;
    do_reset();
    sel = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (busy1 !== 1'b0 || busy4 !== 1'b0) begin
        errors++;
        $display("FAIL start_abort_idle cyc%0d: busy1=%b busy4=%b, want 0/0", k, busy1, busy4);
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_xor_stuck();
    test_all_zero();
    test_random();
    test_abort();
    test_abort_finish();
    test_async_reset();
    test_start_held();
    test_start_abort_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
